uart_burst_bridge: RTL and testbench

UART_BURST_BRIDGE -- requirements
Module: uart_burst_bridge

---
 rtl/uart_burst_bridge.sv | 247 ++++++++++++++++++++++++
 tb/tb_uart_burst_bridge.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_burst_bridge.sv
// UART-to-bus burst bridge: parses command/address/length frames from a byte stream and
// runs burst writes (acknowledged with 8'h5A) or burst reads streamed back over the UART.
module uart_burst_bridge #(
  parameter int          AW      = 16,
  parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [7:0]    rx_data,
  input  logic          new_rx_data,
  output logic [7:0]    tx_data,
  output logic          new_tx_data,
  input  logic          tx_busy,
  output logic [AW-1:0] int_address,
  output logic [7:0]    int_wr_data,
  output logic          int_write,
  output logic          int_read,
  input  logic [7:0]    int_rd_data,
  output logic          int_req,
  input  logic          int_gnt,
  output logic          cmd_err,
  output logic          busy
);

  localparam logic [1:0] LAST_ADDR_BYTE = 2'(AW / 8 - 1);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    ADDR  = 4'd1,
    LEN   = 4'd2,
    WDATA = 4'd3,
    WBUS  = 4'd4,
    RBUS  = 4'd5,
    RCAP  = 4'd6,
    RTX   = 4'd7,
    ACK   = 4'd8
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic [8:0]    cnt_q, cnt_d;
  logic          wr_op_q, wr_op_d;
  logic [15:0]   to_q, to_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          new_tx_data_q, new_tx_data_d;
  logic          int_write_q, int_write_d;
  logic          int_read_q, int_read_d;
  logic          int_req_q, int_req_d;
  logic          cmd_err_q, cmd_err_d;
  logic          busy_q, busy_d;

  logic opcode_ok;
  logic opcode_wr;
  logic in_rx_phase;
  logic timeout_hit;
  logic count_last;

  assign opcode_wr   = (rx_data[7:4] == 4'h1);
  assign opcode_ok   = opcode_wr || (rx_data[7:4] == 4'h2);
  assign in_rx_phase = (state_q == ADDR) || (state_q == LEN) || (state_q == WDATA);
  // Silence counter fires when TIMEOUT cycles pass with no byte; a byte in the same cycle wins.
  assign timeout_hit = in_rx_phase && !new_rx_data && (TIMEOUT != 16'd0) &&
                       (to_q == TIMEOUT - 16'd1);
  assign count_last  = (cnt_q == 9'd1);

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      byte_cnt_q    <= 2'd0;
      addr_q        <= '0;
      wr_data_q     <= 8'd0;
      cnt_q         <= 9'd0;
      wr_op_q       <= 1'b0;
      to_q          <= 16'd0;
      tx_data_q     <= 8'd0;
      new_tx_data_q <= 1'b0;
      int_write_q   <= 1'b0;
      int_read_q    <= 1'b0;
      int_req_q     <= 1'b0;
      cmd_err_q     <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      byte_cnt_q    <= byte_cnt_d;
      addr_q        <= addr_d;
      wr_data_q     <= wr_data_d;
      cnt_q         <= cnt_d;
      wr_op_q       <= wr_op_d;
      to_q          <= to_d;
      tx_data_q     <= tx_data_d;
      new_tx_data_q <= new_tx_data_d;
      int_write_q   <= int_write_d;
      int_read_q    <= int_read_d;
      int_req_q     <= int_req_d;
      cmd_err_q     <= cmd_err_d;
      busy_q        <= busy_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (new_rx_data && opcode_ok) state_d = ADDR;
        else                          state_d = IDLE;
      end
      ADDR: begin
        if (new_rx_data)      state_d = (byte_cnt_q == LAST_ADDR_BYTE) ? LEN : ADDR;
        else if (timeout_hit) state_d = IDLE;
        else                  state_d = ADDR;
      end
      LEN: begin
        if (new_rx_data)      state_d = wr_op_q ? WDATA : RBUS;
        else if (timeout_hit) state_d = IDLE;
        else                  state_d = LEN;
      end
      WDATA: begin
        if (new_rx_data)      state_d = WBUS;
        else if (timeout_hit) state_d = IDLE;
        else                  state_d = WDATA;
      end
      WBUS: begin
        // int_write_q high means the strobe is on the bus this cycle: step to the next beat.
        if (new_rx_data)      state_d = IDLE;
        else if (int_write_q) state_d = count_last ? ACK : WDATA;
        else                  state_d = WBUS;
      end
      RBUS: begin
        if (int_gnt) state_d = RCAP;
        else         state_d = RBUS;
      end
      RCAP: begin
        if (int_read_q) state_d = RCAP;
        else            state_d = RTX;
      end
      RTX: begin
        if (!tx_busy) state_d = count_last ? IDLE : RBUS;
        else          state_d = RTX;
      end
      ACK: begin
        if (!tx_busy) state_d = IDLE;
        else          state_d = ACK;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath updates and strobe generation.
  always_comb begin
    byte_cnt_d    = byte_cnt_q;
    addr_d        = addr_q;
    wr_data_d     = wr_data_q;
    cnt_d         = cnt_q;
    wr_op_d       = wr_op_q;
    tx_data_d     = tx_data_q;
    new_tx_data_d = 1'b0;
    int_write_d   = 1'b0;
    int_read_d    = 1'b0;
    cmd_err_d     = 1'b0;
    busy_d        = (state_d != IDLE);
    int_req_d     = !((state_d == IDLE) || (state_d == ADDR) || (state_d == LEN));
    case (state_q)
      IDLE: begin
        if (new_rx_data && opcode_ok) begin
          wr_op_d    = opcode_wr;
          byte_cnt_d = 2'd0;
        end else begin
          cmd_err_d = new_rx_data;
        end
      end
      ADDR: begin
        if (new_rx_data) begin
          addr_d     = (addr_q << 4'd8) | AW'(rx_data);
          byte_cnt_d = byte_cnt_q + 2'd1;
        end else begin
          cmd_err_d = timeout_hit;
        end
      end
      LEN: begin
        if (new_rx_data) cnt_d = (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
        else             cmd_err_d = timeout_hit;
      end
      WDATA: begin
        if (new_rx_data) wr_data_d = rx_data;
        else             cmd_err_d = timeout_hit;
      end
      WBUS: begin
        if (new_rx_data) begin
          cmd_err_d = 1'b1;
        end else if (int_write_q) begin
          addr_d = addr_q + AW'(1);
          cnt_d  = cnt_q - 9'd1;
        end else begin
          int_write_d = int_gnt;
        end
      end
      RBUS: begin
        int_read_d = int_gnt;
      end
      RCAP: begin
        if (!int_read_q) tx_data_d = int_rd_data;
        else             tx_data_d = tx_data_q;
      end
      RTX: begin
        if (!tx_busy) begin
          new_tx_data_d = 1'b1;
          addr_d        = addr_q + AW'(1);
          cnt_d         = cnt_q - 9'd1;
        end else begin
          new_tx_data_d = 1'b0;
        end
      end
      ACK: begin
        if (!tx_busy) begin
          new_tx_data_d = 1'b1;
          tx_data_d     = 8'h5A;
        end else begin
          new_tx_data_d = 1'b0;
        end
      end
      default: begin
        cmd_err_d = 1'b0;
      end
    endcase
  end

  // Inter-byte silence counter, held at zero outside the receive phases.
  always_comb begin
    if (in_rx_phase && !new_rx_data && !timeout_hit && (TIMEOUT != 16'd0)) to_d = to_q + 16'd1;
    else                                                                      to_d = 16'd0;
  end

  assign tx_data     = tx_data_q;
  assign new_tx_data = new_tx_data_q;
  assign int_address = addr_q;
  assign int_wr_data = wr_data_q;
  assign int_write   = int_write_q;
  assign int_read    = int_read_q;
  assign int_req     = int_req_q;
  assign cmd_err     = cmd_err_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_uart_burst_bridge.sv
// Directed bench for uart_burst_bridge (AW=16, TIMEOUT=1000) with a bus/UART responder model.
module tb_uart_burst_bridge;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        new_rx_data;
  logic [7:0]  tx_data;
  logic        new_tx_data;
  logic        tx_busy;
  logic [15:0] int_address;
  logic [7:0]  int_wr_data;
  logic        int_write;
  logic        int_read;
  logic [7:0]  int_rd_data;
  logic        int_req;
  logic        int_gnt;
  logic        cmd_err;
  logic        busy;

  uart_burst_bridge #(.AW(16), .TIMEOUT(16'd1000)) dut (
    .clock(clock), .reset(reset), .rx_data(rx_data), .new_rx_data(new_rx_data),
    .tx_data(tx_data), .new_tx_data(new_tx_data), .tx_busy(tx_busy),
    .int_address(int_address), .int_wr_data(int_wr_data), .int_write(int_write),
    .int_read(int_read), .int_rd_data(int_rd_data), .int_req(int_req),
    .int_gnt(int_gnt), .cmd_err(cmd_err), .busy(busy)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] wr_addr_log [0:1023];
  logic [7:0]  wr_data_log [0:1023];
  logic [15:0] rd_addr_log [0:1023];
  logic [7:0]  tx_log      [0:1023];
  int   wr_cnt = 0, rd_cnt = 0, tx_cnt = 0, err_cnt = 0, viol = 0;
  int   tx_busy_len = 0, busy_left = 0;
  logic       rd_pend = 1'b0;
  logic [7:0] rd_pend_val = 8'h00;

  // Responder: logs strobes, returns address[7:0] only in the cycle after int_read,
  // models a transmitter that stays busy for tx_busy_len cycles, flags strobe overlaps.
  always @(negedge clock) begin
    if (int_write === 1'b1 && wr_cnt < 1024) begin
      wr_addr_log[wr_cnt] = int_address;
      wr_data_log[wr_cnt] = int_wr_data;
      wr_cnt++;
    end
    if (int_read === 1'b1) begin
      if (rd_cnt < 1024) rd_addr_log[rd_cnt] = int_address;
      rd_cnt++;
      rd_pend     = 1'b1;
      rd_pend_val = int_address[7:0];
      int_rd_data = 8'hC3;
    end else if (rd_pend) begin
      int_rd_data = rd_pend_val;
      rd_pend     = 1'b0;
    end else begin
      int_rd_data = 8'hC3;
    end
    if (cmd_err === 1'b1) err_cnt++;
    if (int'(int_write === 1'b1) + int'(int_read === 1'b1) + int'(new_tx_data === 1'b1) +
        int'(cmd_err === 1'b1) > 1) viol++;
    if (reset === 1'b1) begin
      tx_busy   = 1'b0;
      busy_left = 0;
    end else if (new_tx_data === 1'b1) begin
      if (tx_busy) viol++;
      if (tx_cnt < 1024) tx_log[tx_cnt] = tx_data;
      tx_cnt++;
      busy_left = tx_busy_len;
      tx_busy   = (tx_busy_len != 0);
    end else if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) tx_busy = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data     = b;
    new_rx_data = 1'b1;
    tick(1);
    new_rx_data = 1'b0;
    rx_data     = 8'hFF;
    tick(3);
  endtask

  task automatic wait_idle(input int max_cycles);
    int n = 0;
    while (busy !== 1'b0 && n < max_cycles) begin
      tick(1);
      n++;
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; new_rx_data = 1'b0; rx_data = 8'h00; int_gnt = 1'b1;
    tick(3);
    vectors++;
    if ({tx_data, new_tx_data, int_address, int_wr_data, int_write, int_read,
         int_req, cmd_err, busy} !== 45'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h expected 0", {tx_data, new_tx_data, int_address,
               int_wr_data, int_write, int_read, int_req, cmd_err, busy});
    end
    reset = 1'b0;
    tick(2);
    vectors++;
    if (busy !== 1'b0 || int_req !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: busy=%b int_req=%b expected 0 0", busy, int_req);
    end
  endtask

  task automatic test_write();
    int wb = wr_cnt, tb = tx_cnt, eb = err_cnt, vb = viol;
    int_gnt = 1'b1; tx_busy_len = 3;
    send_byte(8'h10); send_byte(8'h12); send_byte(8'h34);
    vectors++;
    if (int_req !== 1'b0) begin
      miscompares++; $display("FAIL wr_req_before_len: got %b expected 0", int_req);
    end
    rx_data = 8'h02; new_rx_data = 1'b1; tick(1); new_rx_data = 1'b0;
    vectors++;
    if (int_req !== 1'b1) begin
      miscompares++; $display("FAIL wr_req_after_len: got %b expected 1", int_req);
    end
    tick(3);
    send_byte(8'hAA); send_byte(8'hBB);
    wait_idle(200);
    vectors++;
    if (wr_cnt - wb !== 2) begin
      miscompares++; $display("FAIL wr_count: got %0d expected 2", wr_cnt - wb);
    end
    vectors++;
    if ({wr_addr_log[wb], wr_data_log[wb]} !== 24'h1234AA) begin
      miscompares++;
      $display("FAIL wr_beat0: got %h expected 1234AA", {wr_addr_log[wb], wr_data_log[wb]});
    end
    vectors++;
    if ({wr_addr_log[wb+1], wr_data_log[wb+1]} !== 24'h1235BB) begin
      miscompares++;
      $display("FAIL wr_beat1: got %h expected 1235BB", {wr_addr_log[wb+1], wr_data_log[wb+1]});
    end
    vectors++;
    if (tx_cnt - tb !== 1 || tx_log[tb] !== 8'h5A) begin
      miscompares++;
      $display("FAIL wr_ack: got %0d bytes first %h expected 1 byte 5A", tx_cnt - tb, tx_log[tb]);
    end
    vectors++;
    if (int_req !== 1'b0 || err_cnt != eb || viol != vb) begin
      miscompares++;
      $display("FAIL wr_after: int_req=%b errs=%0d viol=%0d expected 0 0 0",
               int_req, err_cnt - eb, viol - vb);
    end
  endtask

  task automatic test_read_gnt_delay();
    int rb = rd_cnt, tb = tx_cnt, wb = wr_cnt, eb = err_cnt, vb = viol;
    int_gnt = 1'b0; tx_busy_len = 10;
    send_byte(8'h20); send_byte(8'h00); send_byte(8'h10); send_byte(8'h03);
    tick(50);
    vectors++;
    if (rd_cnt != rb || int_req !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL rd_gnt_wait: reads=%0d int_req=%b busy=%b expected 0 1 1",
               rd_cnt - rb, int_req, busy);
    end
    int_gnt = 1'b1;
    wait_idle(500);
    vectors++;
    if (rd_cnt - rb !== 3 || tx_cnt - tb !== 3 || wr_cnt != wb) begin
      miscompares++;
      $display("FAIL rd_counts: reads=%0d tx=%0d writes=%0d expected 3 3 0",
               rd_cnt - rb, tx_cnt - tb, wr_cnt - wb);
    end
    vectors++;
    if ({rd_addr_log[rb], rd_addr_log[rb+1], rd_addr_log[rb+2]} !== 48'h0010_0011_0012) begin
      miscompares++;
      $display("FAIL rd_addrs: got %h %h %h expected 0010 0011 0012",
               rd_addr_log[rb], rd_addr_log[rb+1], rd_addr_log[rb+2]);
    end
    vectors++;
    if ({tx_log[tb], tx_log[tb+1], tx_log[tb+2]} !== 24'h101112) begin
      miscompares++;
      $display("FAIL rd_tx: got %h %h %h expected 10 11 12", tx_log[tb], tx_log[tb+1], tx_log[tb+2]);
    end
    vectors++;
    if (viol != vb || err_cnt != eb || int_req !== 1'b0) begin
      miscompares++;
      $display("FAIL rd_after: viol=%0d errs=%0d int_req=%b expected 0 0 0",
               viol - vb, err_cnt - eb, int_req);
    end
  endtask

  task automatic test_wrap_n0();
    int rb = rd_cnt, tb = tx_cnt, vb = viol;
    logic [15:0] exp_a;
    int_gnt = 1'b1; tx_busy_len = 2;
    send_byte(8'h20); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h00);
    wait_idle(4000);
    vectors++;
    if (rd_cnt - rb !== 256 || tx_cnt - tb !== 256) begin
      miscompares++;
      $display("FAIL wrap_counts: reads=%0d tx=%0d expected 256 256", rd_cnt - rb, tx_cnt - tb);
    end
    for (int i = 0; i < 256; i++) begin
      exp_a = 16'hFFFF + 16'(i);
      vectors++;
      if (rd_addr_log[rb+i] !== exp_a || tx_log[tb+i] !== exp_a[7:0]) begin
        miscompares++;
        $display("FAIL wrap_beat%0d: addr %h tx %h expected %h %h",
                 i, rd_addr_log[rb+i], tx_log[tb+i], exp_a, exp_a[7:0]);
      end
    end
    vectors++;
    if (viol != vb) begin
      miscompares++; $display("FAIL wrap_viol: got %0d expected 0", viol - vb);
    end
  endtask

  task automatic test_timeout_badop();
    int eb = err_cnt, n = 0;
    send_byte(8'h10); send_byte(8'h12);
    tick(900);
    vectors++;
    if (err_cnt != eb || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL to_early: errs=%0d busy=%b expected 0 1", err_cnt - eb, busy);
    end
    while (err_cnt == eb && n < 200) begin
      tick(1);
      n++;
    end
    // Silence starts at the edge accepting 8'h12; 1000 quiet cycles later the error is seen.
    vectors++;
    if (err_cnt - eb !== 1 || n < 95 || n > 99) begin
      miscompares++;
      $display("FAIL to_fire: errs=%0d after %0d cycles expected 1 within 95..99", err_cnt - eb, n);
    end
    vectors++;
    if (int_req !== 1'b0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL to_after: int_req=%b busy=%b expected 0 0", int_req, busy);
    end
    send_byte(8'h30);
    vectors++;
    if (err_cnt - eb !== 2 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL bad_opcode: errs=%0d busy=%b expected 2 0", err_cnt - eb, busy);
    end
  endtask

  task automatic test_overrun();
    int eb = err_cnt, wb = wr_cnt;
    int_gnt = 1'b0;
    send_byte(8'h1F); send_byte(8'h12); send_byte(8'h34); send_byte(8'h02); send_byte(8'hAA);
    vectors++;
    if (err_cnt != eb || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL ovr_first: errs=%0d busy=%b expected 0 1", err_cnt - eb, busy);
    end
    send_byte(8'hBB);
    vectors++;
    if (err_cnt - eb !== 1 || wr_cnt != wb) begin
      miscompares++;
      $display("FAIL ovr_second: errs=%0d writes=%0d expected 1 0", err_cnt - eb, wr_cnt - wb);
    end
    vectors++;
    if (busy !== 1'b0 || int_req !== 1'b0) begin
      miscompares++; $display("FAIL ovr_after: busy=%b int_req=%b expected 0 0", busy, int_req);
    end
    int_gnt = 1'b1;
  endtask

  task automatic test_reset_mid_read();
    int tb = tx_cnt, n = 0, rb, wb, eb;
    int_gnt = 1'b1; tx_busy_len = 30;
    send_byte(8'h20); send_byte(8'h00); send_byte(8'h40); send_byte(8'h04);
    while (tx_cnt == tb && n < 300) begin
      tick(1);
      n++;
    end
    tick(8);
    vectors++;
    if (tx_cnt - tb !== 1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_setup: tx=%0d busy=%b expected 1 1", tx_cnt - tb, busy);
    end
    reset = 1'b1;
    tick(1);
    vectors++;
    if ({tx_data, new_tx_data, int_address, int_wr_data, int_write, int_read,
         int_req, cmd_err, busy} !== 45'd0) begin
      miscompares++;
      $display("FAIL rst_mid_outputs: got %h expected 0", {tx_data, new_tx_data, int_address,
               int_wr_data, int_write, int_read, int_req, cmd_err, busy});
    end
    reset = 1'b0;
    rb = rd_cnt; tb = tx_cnt; wb = wr_cnt; eb = err_cnt;
    tick(40);
    vectors++;
    if (rd_cnt != rb || tx_cnt != tb || wr_cnt != wb || err_cnt != eb || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_quiet: reads=%0d tx=%0d writes=%0d errs=%0d busy=%b expected all 0",
               rd_cnt - rb, tx_cnt - tb, wr_cnt - wb, err_cnt - eb, busy);
    end
    send_byte(8'h10); send_byte(8'h00); send_byte(8'h50); send_byte(8'h01); send_byte(8'h77);
    wait_idle(200);
    vectors++;
    if (wr_cnt - wb !== 1 || {wr_addr_log[wb], wr_data_log[wb]} !== 24'h005077) begin
      miscompares++;
      $display("FAIL rst_new_frame: writes=%0d beat %h expected 1 005077",
               wr_cnt - wb, {wr_addr_log[wb], wr_data_log[wb]});
    end
    vectors++;
    if (tx_cnt - tb !== 1 || tx_log[tb] !== 8'h5A) begin
      miscompares++;
      $display("FAIL rst_new_ack: tx=%0d first %h expected 1 5A", tx_cnt - tb, tx_log[tb]);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_gnt_delay();
    test_wrap_n0();
    test_timeout_badop();
    test_overrun();
    test_reset_mid_read();
    vectors++;
    if (viol != 0) begin
      miscompares++; $display("FAIL strobe_rules: got %0d violations expected 0", viol);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
